pix_stream_checker: RTL and testbench
=====================================

Name: pix_stream_checker

Overview:
- Sink-side monitor for the raster pixel stream emitted by the test-pattern generator: consumes pix_valid/x/y/rgb/frame_done.
- Locks onto frame start, checks that coordinates advance in raster order and that frame_done arrives where required, and accumulates a 32-bit per-frame signature.
- Emits one report per completed frame over a valid/ready interface.
- Sits at the generator's output in simulation and FPGA self-test builds.

Parameters:
- W, 256, pixels per line; must match the generator.
- H, 240, lines per frame; must match the generator.
- GOLDEN_SUM, 32'h0, expected frame signature; used only when the optional feature is enabled.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- pix_valid  in  1  pixel qualifier
- pix_r, pix_g, pix_b  in  8 each  pixel colour
- pix_x, pix_y  in  16 each  pixel coordinates
- frame_done  in  1  generator frame-end pulse
- locked  out  1  checker is in RUN
- err_count  out  16  saturating count of protocol errors
- rpt_valid  out  1  report available
- rpt_ready  in  1  report consumer ready
- rpt_checksum  out  32  frame signature
- rpt_frame  out  16  frame index; wraps at 2^16
- rpt_err  out  1  frame saw a frame_done error
- rpt_overflow  out  1  sticky: a report was dropped
- rpt_match  out  1  signature equals GOLDEN_SUM

Behaviour:
- Reset (clk is the clock; reset rst, synchronous, active-high):
  - All outputs go to 0; state = HUNT; expected x/y = 0; signature = 0; frame index = 0.
  - Reset mid-frame discards the partial frame and any pending report.
- HUNT:
  - Ignores frame_done.
  - Pixel accepted with pix_valid=1, x=0, y=0 → enter RUN. The signature starts from that pixel; expected position becomes (1,0).
- RUN:
  - Each pixel with pix_valid=1 is compared against the expected (ex,ey).
  - Match → fold into signature; advance ex; on ex==W-1 wrap ex to 0 and increment ey.
  - Mismatch → err_count+1; drop the frame with no report; return to HUNT.
  - After a mismatch, the same pixel is re-evaluated as a HUNT candidate, so a pixel at (0,0) relocks in the same cycle.
  - pix_valid=0 holds all state.
- Signature update per accepted pixel: sum_next = {sum[30:0], sum[31]} ^ {8'h00, r, g, b}.
- Frame end:
  - Pixel (W-1,H-1) accepted at cycle T arms a frame_done check at T+1, independent of pix_valid.
  - frame_done=0 at T+1 → err_count+1 and the frame's err bit is set.
  - frame_done=1 at any other cycle in RUN → err_count+1 and the current frame's err bit is set.
  - A frame_done at T+1 that coincides with the next frame's (0,0) pixel is legal; that pixel starts the next frame normally.
  - Report loads at T+2: checksum, frame index, err bit. The frame index then increments.
- Report slot (one entry):
  - rpt_valid stays high until rpt_valid && rpt_ready.
  - If a load and a pop happen in the same cycle, the new report replaces the old one (no bubble).
  - If a load arrives while rpt_valid=1 and rpt_ready=0, the new report is dropped and rpt_overflow is set. rpt_overflow clears only on rst.
  - Output fields are stable while rpt_valid=1.
- err_count saturates at 16'hFFFF.
- locked is registered and equals (state==RUN).

Optional Feature:
- Macro PIX_STREAM_CHECKER_GOLDEN_EN.
- Defined: rpt_match loads (checksum==GOLDEN_SUM) together with the report. A mismatch also increments err_count.
- Undefined: rpt_match is tied 0, there is no comparator, and err_count ignores signatures.

Decomposition:
- Package pix_chk_pkg holds:
  - state enum {HUNT, RUN}
  - report struct {checksum, frame, err, match}
  - signature-step function
  - SIG_W=32 and ERR_W=16 constants
- One sub-module, pix_chk_report_slot: a single-entry valid/ready holding register with overflow flag, generic over the report struct.

Test Plan:
- Clean frame, W=4 H=2: pixel (0,0) rgb=000001, all other pixels 0, frame_done at T+1 → one report with checksum=32'h00000080, frame=0, err=0; err_count=0.
- Three back-to-back clean frames at default W/H with rpt_ready=1 → reports with frame=0,1,2; locked stays 1; no overflow.
- Skip pixel (5,0) at W=8 H=2 → err_count=1; locked drops; no report for that frame; relocks at the next (0,0) and reports the following frame normally.
- W=4 H=2, frame_done withheld at T+1 → err_count=1; report issued with err=1.
- rpt_ready=0 across two clean frames → first report held with stable fields; second dropped; rpt_overflow=1; after rpt_ready=1 the first report pops and rpt_valid falls.
- With PIX_STREAM_CHECKER_GOLDEN_EN, W=4 H=2, GOLDEN_SUM=32'h80 using the first scenario's stimulus → rpt_match=1; with GOLDEN_SUM=0 → rpt_match=0 and err_count=1.

Source files
------------

// File: rtl/pix_chk_pkg.sv
// Shared types, widths and signature step for the pixel-stream checker.
package pix_chk_pkg;

    localparam int SIG_W = 32;
    localparam int ERR_W = 16;

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [SIG_W-1:0] checksum;
        logic [15:0]      frame;
        logic             err;
        logic             match;
    } report_t;

    // Rotate-left-by-one then fold the pixel colour into the low 24 bits.
    function automatic logic [SIG_W-1:0] sig_step(
        input logic [SIG_W-1:0] sum,
        input logic [7:0]       r,
        input logic [7:0]       g,
        input logic [7:0]       b
    );
        return {sum[SIG_W-2:0], sum[SIG_W-1]} ^ {8'h00, r, g, b};
    endfunction

endpackage

// File: rtl/pix_chk_report_slot.sv
// Single-entry valid/ready report register; a load into a full, unpopped slot is
// dropped and sets a sticky overflow flag. Load and pop in one cycle replace the entry.
module pix_chk_report_slot #(
    parameter type rpt_t = logic
) (
    input  logic clk,
    input  logic rst,
    input  logic ld_vld,
    input  rpt_t ld_dat,
    input  logic out_rdy,
    output logic out_vld,
    output rpt_t out_dat,
    output logic overflow
);

    logic vld_q, vld_d;
    rpt_t dat_q, dat_d;
    logic ovf_q, ovf_d;
    logic pop;

    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        ovf_d = ovf_q;
        pop   = vld_q && out_rdy;
        if (ld_vld && (!vld_q || pop)) begin
            vld_d = 1'b1;
            dat_d = ld_dat;
        end else if (ld_vld) begin
            ovf_d = 1'b1;
        end else if (pop) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= 1'b0;
            dat_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
            ovf_q <= ovf_d;
        end
    end

    assign out_vld  = vld_q;
    assign out_dat  = dat_q;
    assign overflow = ovf_q;

endmodule

// File: rtl/pix_stream_checker.sv
// Raster pixel-stream monitor: locks on (0,0), checks raster order and frame_done
// timing, emits one signature report per frame. Golden compare: PIX_STREAM_CHECKER_GOLDEN_EN.
module pix_stream_checker
    import pix_chk_pkg::*;
#(
    parameter int          W          = 256,
    parameter int          H          = 240,
    parameter logic [31:0] GOLDEN_SUM = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_valid,
    input  logic [7:0]        pix_r,
    input  logic [7:0]        pix_g,
    input  logic [7:0]        pix_b,
    input  logic [15:0]       pix_x,
    input  logic [15:0]       pix_y,
    input  logic              frame_done,
    output logic              locked,
    output logic [ERR_W-1:0]  err_count,
    output logic              rpt_valid,
    input  logic              rpt_ready,
    output logic [SIG_W-1:0]  rpt_checksum,
    output logic [15:0]       rpt_frame,
    output logic              rpt_err,
    output logic              rpt_overflow,
    output logic              rpt_match
);

    localparam logic [15:0] X_LAST = 16'(W - 1);
    localparam logic [15:0] Y_LAST = 16'(H - 1);

    state_t             state_q, state_d;
    logic [15:0]        ex_q, ex_d, ey_q, ey_d;
    logic [SIG_W-1:0]   sum_q, sum_d, pend_sum_q, pend_sum_d;
    logic               frm_err_q, frm_err_d, pend_err_q, pend_err_d;
    logic               chk_q, chk_d;
    logic [15:0]        frame_q, frame_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;

    logic               at_exp, at_org, accept;
    logic [2:0]         err_inc;
    logic [ERR_W:0]     err_sum;
    logic               ld_vld;
    report_t            ld_dat, rpt_dat;

    always_comb begin
        state_d    = state_q;
        ex_d       = ex_q;
        ey_d       = ey_q;
        sum_d      = sum_q;
        pend_sum_d = pend_sum_q;
        pend_err_d = pend_err_q;
        frm_err_d  = frm_err_q;
        chk_d      = 1'b0;
        frame_d    = frame_q;
        err_inc    = 3'd0;
        ld_vld     = 1'b0;
        ld_dat     = '0;
        accept     = 1'b0;
        at_exp     = (pix_x == ex_q) && (pix_y == ey_q);
        at_org     = (pix_x == 16'd0) && (pix_y == 16'd0);

        // Cycle after the last pixel: frame_done is mandatory here and the report is built.
        if (chk_q) begin
            ld_vld          = 1'b1;
            ld_dat.checksum = pend_sum_q;
            ld_dat.frame    = frame_q;
            ld_dat.err      = pend_err_q | ~frame_done;
            frame_d         = frame_q + 16'd1;
            if (!frame_done) err_inc = err_inc + 3'd1;
`ifdef PIX_STREAM_CHECKER_GOLDEN_EN
            ld_dat.match = (pend_sum_q == GOLDEN_SUM);
            if (pend_sum_q != GOLDEN_SUM) err_inc = err_inc + 3'd1;
`endif
        end

        if (state_q == RUN && frame_done && !chk_q) begin
            err_inc   = err_inc + 3'd1;
            frm_err_d = 1'b1;
        end

        if (pix_valid) begin
            if (state_q == RUN && at_exp) begin
                accept = 1'b1;
            end else begin
                // Out-of-order pixel drops the frame, then gets a second look as a lock candidate.
                if (state_q == RUN) err_inc = err_inc + 3'd1;
                state_d   = HUNT;
                ex_d      = 16'd0;
                ey_d      = 16'd0;
                frm_err_d = 1'b0;
                accept    = at_org;
            end
        end

        if (accept) begin
            state_d = RUN;
            sum_d   = sig_step(at_org ? '0 : sum_q, pix_r, pix_g, pix_b);
            if (pix_x == X_LAST) begin
                ex_d = 16'd0;
                ey_d = (pix_y == Y_LAST) ? 16'd0 : pix_y + 16'd1;
            end else begin
                ex_d = pix_x + 16'd1;
                ey_d = pix_y;
            end
            if (pix_x == X_LAST && pix_y == Y_LAST) begin
                chk_d      = 1'b1;
                pend_sum_d = sum_d;
                pend_err_d = frm_err_d;
                frm_err_d  = 1'b0;
            end
        end

        err_sum   = {1'b0, err_cnt_q} + {{(ERR_W-2){1'b0}}, err_inc};
        err_cnt_d = err_sum[ERR_W] ? {ERR_W{1'b1}} : err_sum[ERR_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HUNT;
            ex_q       <= '0;
            ey_q       <= '0;
            sum_q      <= '0;
            pend_sum_q <= '0;
            pend_err_q <= 1'b0;
            frm_err_q  <= 1'b0;
            chk_q      <= 1'b0;
            frame_q    <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            ex_q       <= ex_d;
            ey_q       <= ey_d;
            sum_q      <= sum_d;
            pend_sum_q <= pend_sum_d;
            pend_err_q <= pend_err_d;
            frm_err_q  <= frm_err_d;
            chk_q      <= chk_d;
            frame_q    <= frame_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    pix_chk_report_slot #(.rpt_t(report_t)) u_slot (
        .clk      (clk),
        .rst      (rst),
        .ld_vld   (ld_vld),
        .ld_dat   (ld_dat),
        .out_rdy  (rpt_ready),
        .out_vld  (rpt_valid),
        .out_dat  (rpt_dat),
        .overflow (rpt_overflow)
    );

    assign locked       = (state_q == RUN);
    assign err_count    = err_cnt_q;
    assign rpt_checksum = rpt_dat.checksum;
    assign rpt_frame    = rpt_dat.frame;
    assign rpt_err      = rpt_dat.err;
    assign rpt_match    = rpt_dat.match;

endmodule

// File: tb/tb_pix_stream_checker.sv
// Scoreboard bench for pix_stream_checker on an 8x2 raster: directed frames with
// one non-zero pixel each, so every signature is a hand-computed rotate of that colour.
module tb_pix_stream_checker;
    import pix_chk_pkg::*;

    localparam int          W  = 8;
    localparam int          H  = 2;
    localparam logic [31:0] GS = 32'h0000_8000;
`ifdef PIX_STREAM_CHECKER_GOLDEN_EN
    localparam bit GOLD = 1'b1;
`else
    localparam bit GOLD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_valid = 1'b0;
    logic [7:0]  pix_r = '0, pix_g = '0, pix_b = '0;
    logic [15:0] pix_x = '0, pix_y = '0;
    logic        frame_done = 1'b0;
    logic        locked;
    logic [15:0] err_count;
    logic        rpt_valid;
    logic        rpt_ready = 1'b1;
    logic [31:0] rpt_checksum;
    logic [15:0] rpt_frame;
    logic        rpt_err, rpt_overflow, rpt_match;

    always #5 clk = ~clk;

    pix_stream_checker #(.W(W), .H(H), .GOLDEN_SUM(GS)) dut (
        .clk(clk), .rst(rst), .pix_valid(pix_valid),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .pix_x(pix_x), .pix_y(pix_y), .frame_done(frame_done),
        .locked(locked), .err_count(err_count),
        .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
        .rpt_checksum(rpt_checksum), .rpt_frame(rpt_frame),
        .rpt_err(rpt_err), .rpt_overflow(rpt_overflow), .rpt_match(rpt_match)
    );

    int      n_cmp = 0;
    int      n_bad = 0;
    int      exp_frame = 0;
    int      exp_err = 0;
    report_t exp_q[$];
    report_t mon_exp, mon_act;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input int x, input int y, input logic [23:0] rgb, input logic fd);
        pix_valid  = 1'b1;
        pix_x      = 16'(x);
        pix_y      = 16'(y);
        {pix_r, pix_g, pix_b} = rgb;
        frame_done = fd;
        tick();
    endtask

    task automatic idle(input logic fd);
        pix_valid  = 1'b0;
        frame_done = fd;
        tick();
        frame_done = 1'b0;
    endtask

    // Full clean frame; raster index k carries colour v, the rest are black.
    task automatic frame(input int k, input logic [23:0] v, input logic first_fd);
        for (int i = 0; i < W*H; i++)
            pix(i % W, i / W, (i == k) ? v : 24'h0, (i == 0) ? first_fd : 1'b0);
    endtask

    task automatic expect_rpt(input logic [31:0] cks, input logic err, input bit keep);
        report_t r;
        logic    m;
        m = GOLD && (cks == GS);
        if (GOLD && !m) exp_err++;
        r.checksum = cks;
        r.frame    = 16'(exp_frame);
        r.err      = err;
        r.match    = m;
        if (keep) exp_q.push_back(r);
        exp_frame++;
    endtask

    always @(negedge clk) begin
        if (!rst && rpt_valid && rpt_ready) begin
            n_cmp++;
            mon_act = '{rpt_checksum, rpt_frame, rpt_err, rpt_match};
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_report: got cks=%h frame=%0d err=%0b match=%0b, none expected",
                         rpt_checksum, rpt_frame, rpt_err, rpt_match);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp)
                begin
                    n_bad++;
                    $display("FAIL report: got cks=%h frame=%0d err=%0b match=%0b, expected cks=%h frame=%0d err=%0b match=%0b",
                             mon_act.checksum, mon_act.frame, mon_act.err, mon_act.match,
                             mon_exp.checksum, mon_exp.frame, mon_exp.err, mon_exp.match);
                end
            end
        end
    end

    initial begin
        // Reset state
        tick(); tick();
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_rpt_valid", 32'(rpt_valid), 32'd0);
        check("rst_overflow", 32'(rpt_overflow), 32'd0);
        check("rst_match", 32'(rpt_match), 32'd0);
        check("rst_checksum", rpt_checksum, 32'd0);
        check("rst_frame", 32'(rpt_frame), 32'd0);
        rst = 1'b0;
        tick();

        // Clean frame: colour 1 at (0,0), then 15 rotations -> 0x8000
        expect_rpt(32'h0000_8000, 1'b0, 1'b1);
        frame(0, 24'h000001, 1'b0);
        check("clean_locked", 32'(locked), 32'd1);
        idle(1'b1); idle(1'b0); idle(1'b0);
        check("clean_err_count", 32'(err_count), 32'(exp_err));

        // Three back-to-back frames, frame_done coinciding with the next (0,0)
        expect_rpt(32'h00AB_CDEF, 1'b0, 1'b1);
        frame(15, 24'hABCDEF, 1'b0);
        check("b2b_locked0", 32'(locked), 32'd1);
        expect_rpt(32'h0000_FF00, 1'b0, 1'b1);
        frame(7, 24'h0000FF, 1'b1);
        check("b2b_locked1", 32'(locked), 32'd1);
        expect_rpt(32'h0100_0000, 1'b0, 1'b1);
        frame(14, 24'h800000, 1'b1);
        check("b2b_locked2", 32'(locked), 32'd1);
        idle(1'b1); idle(1'b0); idle(1'b0);
        check("b2b_overflow", 32'(rpt_overflow), 32'd0);
        check("b2b_err_count", 32'(err_count), 32'(exp_err));

        // Skip pixel (5,0): frame dropped, lock lost; frame_done in HUNT ignored
        for (int i = 0; i < 5; i++) pix(i, 0, 24'h0, 1'b0);
        pix(6, 0, 24'h0, 1'b0);
        exp_err++;
        check("skip_unlocked", 32'(locked), 32'd0);
        idle(1'b1); idle(1'b0);
        check("skip_err_count", 32'(err_count), 32'(exp_err));
        check("skip_no_report", 32'(rpt_valid), 32'd0);
        expect_rpt(32'h0000_8000, 1'b0, 1'b1);
        frame(0, 24'h000001, 1'b0);
        check("relock_locked", 32'(locked), 32'd1);
        idle(1'b1); idle(1'b0); idle(1'b0);

        // frame_done withheld after the last pixel
        expect_rpt(32'h0000_8000, 1'b1, 1'b1);
        frame(0, 24'h000001, 1'b0);
        idle(1'b0);
        exp_err++;
        idle(1'b0); idle(1'b0);
        check("nofd_err_count", 32'(err_count), 32'(exp_err));

        // Consumer stalled across two frames: first held, second dropped
        rpt_ready = 1'b0;
        expect_rpt(32'h00AB_CDEF, 1'b0, 1'b1);
        frame(15, 24'hABCDEF, 1'b0);
        idle(1'b1); idle(1'b0);
        check("hold_valid", 32'(rpt_valid), 32'd1);
        check("hold_checksum", rpt_checksum, 32'h00AB_CDEF);
        expect_rpt(32'h0000_FF00, 1'b0, 1'b0);
        frame(7, 24'h0000FF, 1'b0);
        idle(1'b1); idle(1'b0);
        check("ovf_flag", 32'(rpt_overflow), 32'd1);
        check("ovf_valid", 32'(rpt_valid), 32'd1);
        check("ovf_stable_checksum", rpt_checksum, 32'h00AB_CDEF);
        check("ovf_stable_frame", 32'(rpt_frame), 32'd6);
        rpt_ready = 1'b1;
        tick();
        check("pop_valid_low", 32'(rpt_valid), 32'd0);
        check("ovf_sticky", 32'(rpt_overflow), 32'd1);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check("drain_pending", 32'(exp_q.size()), 32'd0);
        check("final_err_count", 32'(err_count), 32'(exp_err));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
